// File: rtl/disp_queue_mc_if.sv
// disp_queue_mc_if
//   Bundles the rename-side enqueue group and the per-channel dispatch
//   lanes of the multi-channel dispatch queue.
//
//   Enqueue group (rename -> queue)
//     i_flush     squash everything queued; blocks enqueue this cycle
//     i_enq_vld   [IN_WID]          per-lane uop valid, may be sparse
//     i_enq_ch    [IN_WID*CHW]      per-lane target channel
//     i_enq_data  [IN_WID*DATA_W]   per-lane packed DQ entry
//     o_enq_rdy                     whole group can be accepted
//   Dispatch lanes (queue -> exec blocks), lane k = ch*OUT_WID + i
//     o_disp_req  [NUM_CH*OUT_WID]         lane holds a valid entry
//     i_disp_rdy  [NUM_CH*OUT_WID]         exec block can take lane
//     o_disp_data [NUM_CH*OUT_WID*DATA_W]  lane entry
//     o_count     [NUM_CH*CNTW]            registered occupancy per channel
//
//   master: the rename/exec side that drives the i_* signals.
//   slave : the queue itself.
interface disp_queue_mc_if #(
    parameter int NUM_CH  = 2,
    parameter int IN_WID  = 4,
    parameter int OUT_WID = 2,
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 64,
    parameter int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNTW    = $clog2(DEPTH) + 1
);
    logic                               i_flush;
    logic [IN_WID-1:0]                  i_enq_vld;
    logic [IN_WID*CHW-1:0]              i_enq_ch;
    logic [IN_WID*DATA_W-1:0]           i_enq_data;
    logic                               o_enq_rdy;
    logic [NUM_CH*OUT_WID-1:0]          o_disp_req;
    logic [NUM_CH*OUT_WID-1:0]          i_disp_rdy;
    logic [NUM_CH*OUT_WID*DATA_W-1:0]   o_disp_data;
    logic [NUM_CH*CNTW-1:0]             o_count;

    modport master (
        output i_flush, i_enq_vld, i_enq_ch, i_enq_data, i_disp_rdy,
        input  o_enq_rdy, o_disp_req, o_disp_data, o_count
    );

    modport slave (
        input  i_flush, i_enq_vld, i_enq_ch, i_enq_data, i_disp_rdy,
        output o_enq_rdy, o_disp_req, o_disp_data, o_count
    );
endinterface

// File: rtl/disp_queue_mc.sv
// disp_queue_mc
//   Multi-channel dispatch queue between rename and the execution blocks.
//   Up to IN_WID renamed uops per cycle are steered by channel id into one
//   in-order circular FIFO per channel; each channel presents its OUT_WID
//   oldest entries to its exec block over per-lane req/rdy handshakes.
//
//   Ports
//     clk  clock
//     rst  synchronous active-high reset (empties every channel)
//     bus  disp_queue_mc_if.slave: enqueue group, dispatch lanes, occupancy
module disp_queue_mc #(
    parameter int NUM_CH  = 2,
    parameter int IN_WID  = 4,
    parameter int OUT_WID = 2,
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 64,
    parameter int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNTW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    disp_queue_mc_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is never reset: only pointers and counts define validity.
    logic [DATA_W-1:0] mem   [NUM_CH][DEPTH];
    logic [PW-1:0]     head  [NUM_CH];
    logic [PW-1:0]     tail  [NUM_CH];
    logic [CNTW-1:0]   count [NUM_CH];

    logic [CHW-1:0]    lane_ch  [IN_WID];
    logic [IN_WID-1:0] lane_ok;
    logic [PW-1:0]     lane_ofs [IN_WID];
    logic [CNTW-1:0]   need     [NUM_CH];
    logic [CNTW-1:0]   enq_n    [NUM_CH];
    logic [CNTW-1:0]   deq_n    [NUM_CH];
    logic              enq_rdy;
    logic              do_enq;
    logic              chain;

    logic [NUM_CH*OUT_WID-1:0]        req_v;
    logic [NUM_CH*OUT_WID*DATA_W-1:0] data_v;
    logic [NUM_CH*CNTW-1:0]           count_v;

    // Enqueue: per-channel demand, and each lane's slot offset from its
    // channel's tail (ascending lane order compacts lanes of one channel).
    // Acceptance looks only at registered counts, so lanes freed by this
    // cycle's dispatch are not credited and rdy never depends on i_disp_rdy.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            need[c] = '0;
        end
        for (int l = 0; l < IN_WID; l++) begin
            lane_ch[l]  = bus.i_enq_ch[l*CHW +: CHW];
            lane_ok[l]  = bus.i_enq_vld[l] && (int'(lane_ch[l]) < NUM_CH);
            lane_ofs[l] = '0;
            if (lane_ok[l]) begin
                lane_ofs[l]      = PW'(need[lane_ch[l]]);
                need[lane_ch[l]] = need[lane_ch[l]] + CNTW'(1);
            end
        end
        enq_rdy = !bus.i_flush;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((CNTW'(DEPTH) - count[c]) < need[c]) begin
                enq_rdy = 1'b0;
            end
        end
        do_enq = enq_rdy && (|bus.i_enq_vld);
        for (int c = 0; c < NUM_CH; c++) begin
            enq_n[c] = do_enq ? need[c] : '0;
        end
    end

    // Dispatch: lane i shows entry head+i. Only a contiguous prefix of
    // handshaking lanes transfers, so a gap in rdy stops everything above it.
    always_comb begin
        chain = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            chain    = 1'b1;
            deq_n[c] = '0;
            for (int i = 0; i < OUT_WID; i++) begin
                req_v[c*OUT_WID + i] = CNTW'(i) < count[c];
                chain = chain & req_v[c*OUT_WID + i] & bus.i_disp_rdy[c*OUT_WID + i];
                if (chain) begin
                    deq_n[c] = deq_n[c] + CNTW'(1);
                end
                data_v[(c*OUT_WID + i)*DATA_W +: DATA_W] = mem[c][head[c] + PW'(i)];
            end
            count_v[c*CNTW +: CNTW] = count[c];
        end
    end

    // Control state. Flush still lets this cycle's dispatch fires complete
    // (the exec blocks captured them); the queue is emptied at this edge.
    always_ff @(posedge clk) begin
        if (rst || bus.i_flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                head[c]  <= '0;
                tail[c]  <= '0;
                count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                head[c]  <= head[c] + PW'(deq_n[c]);
                tail[c]  <= tail[c] + PW'(enq_n[c]);
                count[c] <= count[c] + enq_n[c] - deq_n[c];
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int l = 0; l < IN_WID; l++) begin
                if (lane_ok[l]) begin
                    mem[lane_ch[l]][tail[lane_ch[l]] + lane_ofs[l]] <=
                        bus.i_enq_data[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign bus.o_enq_rdy   = enq_rdy;
    assign bus.o_disp_req  = req_v;
    assign bus.o_disp_data = data_v;
    assign bus.o_count     = count_v;

endmodule
